// File: rtl/alu_sched_pkg.sv
// Shared widths and encodings for the ALU scheduler.
package alu_sched_pkg;
   localparam int OPND_W = 5;
   localparam int RES_W  = 6;
   localparam int AOP_W  = 3;
   localparam int BOP_W  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      GRP_A = 1'b0,
      GRP_B = 1'b1
   } grp_t;
endpackage

// File: rtl/alu_rr_arbiter.sv
// Round-robin one-hot grant; the search starts at rr_ptr and wraps.
module alu_rr_arbiter #(
   parameter int N_REQ = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req,
   input  logic                       advance,
   output logic [N_REQ-1:0]           grant,
   output logic [$clog2(N_REQ)-1:0]   grant_idx
);
   localparam int IDX_W = $clog2(N_REQ);

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] idx;

   // Scanning from the far end lets the nearest candidate to rr_ptr win last.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      idx       = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = IDX_W'((int'(rr_ptr) + k) % N_REQ);
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rr_ptr <= '0;
      else if (advance)
         rr_ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
   end
endmodule

// File: rtl/alu_sched.sv
// Shares one ALU between N_REQ requesters, one operation in flight at a time.
// ALU_SCHED_STATS_EN enables the saturating per-requester issue counters.
//
// state | meaning
// IDLE  | arbitrate, accept one request
// ISSUE | drive ALU controls and operands for one cycle
// WAIT  | ALU_LAT cycles, capture alu_c on the last one
// RESP  | hold result for the owner until it is consumed
module alu_sched
   import alu_sched_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int ALU_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ*OPND_W-1:0]   req_a,
   input  logic [N_REQ*OPND_W-1:0]   req_b,
   input  logic [N_REQ-1:0]          req_grp,
   input  logic [N_REQ*AOP_W-1:0]    req_op,
   output logic [N_REQ-1:0]          rsp_valid,
   input  logic [N_REQ-1:0]          rsp_ready,
   output logic [RES_W-1:0]          rsp_c,
   output logic                      alu_en,
   output logic                      alu_a_en,
   output logic                      alu_b_en,
   output logic [AOP_W-1:0]          alu_a_op,
   output logic [BOP_W-1:0]          alu_b_op,
   output logic [OPND_W-1:0]         alu_a,
   output logic [OPND_W-1:0]         alu_b,
   input  logic [RES_W-1:0]          alu_c,
   output logic                      busy,
   output logic [N_REQ*CNT_W-1:0]    issue_cnt
);
   localparam int IDX_W  = $clog2(N_REQ);
   localparam int WAIT_W = 3;

   state_t              state;
   logic [N_REQ-1:0]    grant;
   logic [IDX_W-1:0]    grant_idx;
   logic [IDX_W-1:0]    owner;
   logic [OPND_W-1:0]   opnd_a;
   logic [OPND_W-1:0]   opnd_b;
   grp_t                grp;
   logic [AOP_W-1:0]    op;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                accept;
   logic                is_issue;

   alu_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .advance   (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Gating with rst_n keeps the grant invisible while reset is held.
   assign req_ready = (rst_n && state == IDLE) ? grant : '0;
   assign accept    = |(req_valid & req_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= '0;
         opnd_a   <= '0;
         opnd_b   <= '0;
         grp      <= GRP_A;
         op       <= '0;
         wait_cnt <= '0;
         rsp_c    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  owner  <= grant_idx;
                  opnd_a <= req_a[grant_idx*OPND_W +: OPND_W];
                  opnd_b <= req_b[grant_idx*OPND_W +: OPND_W];
                  grp    <= grp_t'(req_grp[grant_idx]);
                  op     <= req_op[grant_idx*AOP_W +: AOP_W];
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               wait_cnt <= WAIT_W'(ALU_LAT - 1);
               state    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  rsp_c <= alu_c;
                  state <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready[owner])
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // ALU drives decode from the registered state, so reset clears them asynchronously.
   assign is_issue  = (state == ISSUE);
   assign alu_en    = is_issue;
   assign alu_a_en  = is_issue && (grp == GRP_A);
   assign alu_b_en  = is_issue && (grp == GRP_B);
   assign alu_a_op  = alu_a_en ? op : '0;
   assign alu_b_op  = alu_b_en ? op[BOP_W-1:0] : '0;
   assign alu_a     = is_issue ? opnd_a : '0;
   assign alu_b     = is_issue ? opnd_b : '0;
   assign busy      = (state != IDLE);
   assign rsp_valid = (state == RESP) ? (N_REQ'(1) << owner) : '0;

`ifdef ALU_SCHED_STATS_EN
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            cnt <= '0;
         else if (is_issue && owner == IDX_W'(gi) && cnt != '1)
            cnt <= cnt + 1'b1;
      end
      assign issue_cnt[gi*CNT_W +: CNT_W] = cnt;
   end
`else
   assign issue_cnt = '0;
`endif
endmodule
